// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl: round/attempt controller for a BCD number-guessing game.
// Ports: clk, reset (sync, active-high); submit (level, edge-detected inside);
//   guess_digit_1..3 / target_digit_1..3 (BCD, digit_1 = units);
//   round, Max_digit drive the target stage; hint/result_valid report each compare;
//   attempts counts compared guesses this round; win/game_over are terminal flags.
// Optional: define ATTEMPT_LIMIT_EN to end the game after MAX_ATTEMPTS wrong guesses in a round.
module guess_round_ctrl #(
  parameter int MAX_ATTEMPTS = 7,
  parameter int LOAD_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       submit,
  input  logic [3:0] guess_digit_1,
  input  logic [3:0] guess_digit_2,
  input  logic [3:0] guess_digit_3,
  input  logic [3:0] target_digit_1,
  input  logic [3:0] target_digit_2,
  input  logic [3:0] target_digit_3,
  output logic [3:0] round,
  output logic [1:0] Max_digit,
  output logic [1:0] hint,
  output logic       result_valid,
  output logic [3:0] attempts,
  output logic       win,
  output logic       game_over
);
`ifdef ATTEMPT_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  typedef enum logic [2:0] {LOAD, WAIT_GUESS, COMPARE, ADVANCE, DONE} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic sub_q;
  logic [11:0] g, g_n;
  logic [3:0] round_n, attempts_n;
  logic [1:0] md_n, hint_n;
  logic rv_n, win_n, go_n;
  logic rise, bad, limit;
  logic [11:0] t;
  logic [3:0] att_inc;
  logic [1:0] cmp;
  assign rise = submit & ~sub_q;
  assign t = {target_digit_3, target_digit_2, target_digit_1};
  assign bad = (g[3:0] > 4'd9) | (g[7:4] > 4'd9) | (g[11:8] > 4'd9);
  // With every digit in 0..9 the packed BCD word orders exactly like a hundreds-first digit compare.
  assign cmp = g < t ? 2'b01 : g > t ? 2'b10 : 2'b11;
  assign att_inc = attempts == 4'd15 ? 4'd15 : attempts + 4'd1;
  assign limit = LIMIT_EN && att_inc == 4'(MAX_ATTEMPTS);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    g_n = g;
    round_n = round;
    md_n = Max_digit;
    hint_n = hint;
    rv_n = 1'b0;
    attempts_n = attempts;
    win_n = win;
    go_n = game_over;
    case (state)
      LOAD: begin
        cnt_n = cnt == 3'(LOAD_CYCLES - 1) ? 3'd0 : cnt + 3'd1;
        state_n = cnt == 3'(LOAD_CYCLES - 1) ? WAIT_GUESS : LOAD;
      end
      WAIT_GUESS: if (rise) begin
        g_n = {guess_digit_3, guess_digit_2, guess_digit_1};
        state_n = COMPARE;
      end
      COMPARE: begin
        rv_n = 1'b1;
        hint_n = bad ? 2'b00 : cmp;
        attempts_n = bad ? attempts : att_inc;
        go_n = game_over | (!bad && cmp != 2'b11 && limit);
        state_n = bad ? WAIT_GUESS : cmp == 2'b11 ? ADVANCE : limit ? DONE : WAIT_GUESS;
      end
      ADVANCE: if (round == 4'd9) begin
        win_n = 1'b1;
        state_n = DONE;
      end else begin
        round_n = round + 4'd1;
        md_n = round >= 4'd6 ? 2'd3 : round >= 4'd3 ? 2'd2 : 2'd1;
        attempts_n = 4'd0;
        hint_n = 2'b00;
        state_n = LOAD;
      end
      DONE: state_n = DONE;
      default: state_n = LOAD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      cnt <= 3'd0;
      sub_q <= 1'b1;
      g <= 12'd0;
      round <= 4'd1;
      Max_digit <= 2'd1;
      hint <= 2'b00;
      result_valid <= 1'b0;
      attempts <= 4'd0;
      win <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sub_q <= submit;
      g <= g_n;
      round <= round_n;
      Max_digit <= md_n;
      hint <= hint_n;
      result_valid <= rv_n;
      attempts <= attempts_n;
      win <= win_n;
      game_over <= go_n;
    end
  end
endmodule
